// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_model receiver controller.
package uart_pkg;

    typedef enum logic [2:0] {
        HOLD,
        CAL_IDLE,
        CAL_FALL,
        CAL_MEAS,
        RUN
    } t_ctrl_state;

    localparam logic [15:0] SAT16     = 16'hFFFF;
    localparam logic [31:0] DEF_BITS  = 32'd8;
    localparam logic [31:0] DEF_STOPS = 32'd1;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Character stream from the controller FIFO toward the bench console/checker.
interface uart_rx_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/uart_char_fifo.sv
// Small power-of-two character FIFO; head reads as zero while empty.
module uart_char_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DATA_W-1:0]        head,
    output logic                     ovf
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign ovf     = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Configures, calibrates and drains the uart_model receiver.
// Auto-baud calibration is compiled in only with UART_RX_CTRL_AUTOBAUD_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH        = 8,
    parameter int DEFAULT_BAUD_CLKS = 16,
    parameter int ERR_LIMIT         = 3,
    parameter int CAL_SAMPLES       = 4,
    parameter int MIN_BAUD_CLKS     = 4,
    parameter int IDLE_CLKS         = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cfg_baud_clks,
    input  logic [31:0]           cfg_bits,
    input  logic [31:0]           cfg_stops,
    input  logic                  recal,
    input  logic                  rxd_mon,
    input  logic                  rx_rdy,
    input  logic                  rx_err,
    input  logic [31:0]           rx_data,
    output logic                  rx_rst_n,
    output logic [31:0]           ctrl_baud_clks,
    output logic [31:0]           ctrl_bits,
    output logic [31:0]           ctrl_stops,
    uart_rx_ctrl_if.master        ch,
    output logic                  locked,
    output logic [15:0]           err_cnt,
    output logic [15:0]           ovf_cnt
);
    localparam int DATA_W = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == SAT16) ? v : v + 16'd1;
    endfunction

    function automatic logic [DATA_W-1:0] char_mask(input logic [DATA_W-1:0] d,
                                                     input logic [31:0] nbits);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) m[i] = (32'(i) < nbits);
        return d & m;
    endfunction

    t_ctrl_state                 state;
    t_ctrl_state                 state_nxt;
    logic                        good_chr;
    logic                        bad_chr;
    logic                        fifo_pop;
    logic                        fifo_ovf;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [DATA_W-1:0]           fifo_head;
    logic [DATA_W-1:0]           push_char;

`ifdef UART_RX_CTRL_AUTOBAUD_EN
    logic [15:0] idle_cnt;
    logic [15:0] width_cnt;
    logic [15:0] pulse_min;
    logic [15:0] min_nxt;
    logic [7:0]  acc_cnt;
    logic [7:0]  err_run;
    logic        accept;

    assign min_nxt = (width_cnt < pulse_min) ? width_cnt : pulse_min;
`endif

    always_comb begin
        state_nxt = state;
        good_chr  = 1'b0;
        bad_chr   = 1'b0;
`ifdef UART_RX_CTRL_AUTOBAUD_EN
        accept    = 1'b0;
`endif
        case (state)
`ifdef UART_RX_CTRL_AUTOBAUD_EN
            HOLD:     state_nxt = CAL_IDLE;
            CAL_IDLE: if (rxd_mon && idle_cnt == 16'(IDLE_CLKS - 1)) state_nxt = CAL_FALL;
            CAL_FALL: if (!rxd_mon) state_nxt = CAL_MEAS;
            CAL_MEAS: begin
                // A rising edge ends the pulse; too short or saturated widths are discarded.
                if (rxd_mon) begin
                    accept = (width_cnt >= 16'(MIN_BAUD_CLKS)) && (width_cnt != SAT16);
                    if (accept && acc_cnt == 8'(CAL_SAMPLES - 1)) state_nxt = RUN;
                    else                                         state_nxt = CAL_FALL;
                end
            end
`else
            HOLD:     state_nxt = RUN;
`endif
            RUN: begin
                good_chr = rx_rdy & ~rx_err;
                bad_chr  = rx_rdy & rx_err;
`ifdef UART_RX_CTRL_AUTOBAUD_EN
                if (recal || (bad_chr && err_run == 8'(ERR_LIMIT - 1))) state_nxt = CAL_IDLE;
`endif
            end
            default:  state_nxt = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= HOLD;
            rx_rst_n       <= 1'b0;
            locked         <= 1'b0;
            ctrl_baud_clks <= 32'(DEFAULT_BAUD_CLKS);
            ctrl_bits      <= DEF_BITS;
            ctrl_stops     <= DEF_STOPS;
            err_cnt        <= '0;
            ovf_cnt        <= '0;
        end else begin
            state    <= state_nxt;
            rx_rst_n <= (state_nxt == RUN);
            locked   <= (state_nxt == RUN);
            if (state != RUN && state_nxt == RUN) begin
                ctrl_bits  <= cfg_bits;
                ctrl_stops <= cfg_stops;
`ifdef UART_RX_CTRL_AUTOBAUD_EN
                ctrl_baud_clks <= {16'h0, min_nxt};
`else
                ctrl_baud_clks <= cfg_baud_clks;
`endif
            end
            if (bad_chr)  err_cnt <= sat_inc16(err_cnt);
            if (fifo_ovf) ovf_cnt <= sat_inc16(ovf_cnt);
        end
    end

`ifdef UART_RX_CTRL_AUTOBAUD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= '0;
            width_cnt <= '0;
            pulse_min <= SAT16;
            acc_cnt   <= '0;
            err_run   <= '0;
        end else begin
            idle_cnt <= (state == CAL_IDLE && rxd_mon) ? idle_cnt + 16'd1 : '0;
            if (state == CAL_FALL)                width_cnt <= 16'd1;
            else if (state == CAL_MEAS && !rxd_mon) width_cnt <= sat_inc16(width_cnt);
            if (state == CAL_IDLE) begin
                pulse_min <= SAT16;
                acc_cnt   <= '0;
            end else if (accept) begin
                pulse_min <= min_nxt;
                acc_cnt   <= acc_cnt + 8'd1;
            end
            if (state_nxt != RUN || good_chr) err_run <= '0;
            else if (bad_chr)                 err_run <= err_run + 8'd1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^rx_data[31:8];
`else
    logic unused_ok;
    assign unused_ok = ^{rx_data[31:8], rxd_mon, recal, IDLE_CLKS != 0,
                         MIN_BAUD_CLKS != 0, CAL_SAMPLES != 0, ERR_LIMIT != 0};
`endif

    assign push_char = char_mask(rx_data[DATA_W-1:0], ctrl_bits);
    assign fifo_pop  = ch.out_valid & ch.out_ready;

    uart_char_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (good_chr),
        .push_data (push_char),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head),
        .ovf       (fifo_ovf)
    );

    assign ch.out_valid = (fifo_count != '0);
    assign ch.out_data  = fifo_head;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl against a queue-based reference model.
// Covers the default build and, with UART_RX_CTRL_AUTOBAUD_EN, calibration.
module tb_uart_rx_ctrl;
    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_baud_clks, cfg_bits, cfg_stops;
    logic        recal, rxd_mon, rx_rdy, rx_err;
    logic [31:0] rx_data;
    logic        rx_rst_n, locked;
    logic [31:0] ctrl_baud_clks, ctrl_bits, ctrl_stops;
    logic [15:0] err_cnt, ovf_cnt;

    uart_rx_ctrl_if #(.DATA_W(8)) ch ();

    uart_rx_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_baud_clks  (cfg_baud_clks),
        .cfg_bits       (cfg_bits),
        .cfg_stops      (cfg_stops),
        .recal          (recal),
        .rxd_mon        (rxd_mon),
        .rx_rdy         (rx_rdy),
        .rx_err         (rx_err),
        .rx_data        (rx_data),
        .rx_rst_n       (rx_rst_n),
        .ctrl_baud_clks (ctrl_baud_clks),
        .ctrl_bits      (ctrl_bits),
        .ctrl_stops     (ctrl_stops),
        .ch             (ch),
        .locked         (locked),
        .err_cnt        (err_cnt),
        .ovf_cnt        (ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: consumer-visible FIFO contents and statistics.
    int mq[$];
    int m_err  = 0;
    int m_ovf  = 0;
    int m_bits = 8;
    bit m_run  = 1'b0;
    bit err_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply the current inputs to the model, clock once, compare the stream and counters.
    task automatic cycle();
        bit pop, push;
        int exp_data;
        pop  = (mq.size() != 0) && ch.out_ready;
        push = m_run && rx_rdy && !rx_err;
        if (m_run && rx_rdy && rx_err && m_err < 65535) m_err++;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() >= FIFO_DEPTH) begin
                if (m_ovf < 65535) m_ovf++;
            end else begin
                mq.push_back(int'(rx_data & 32'hFF) % (1 << m_bits));
            end
        end
        tick();
        if (mq.size() != 0) exp_data = mq[0];
        else                exp_data = 0;
        chk("out_valid", ch.out_valid, (mq.size() != 0) ? 1 : 0);
        chk("out_data", ch.out_data, exp_data);
        chk("err_cnt", err_cnt, m_err);
        chk("ovf_cnt", ovf_cnt, m_ovf);
    endtask

    task automatic model_reset();
        mq.delete();
        m_err = 0;
        m_ovf = 0;
        m_run = 1'b0;
    endtask

`ifdef UART_RX_CTRL_AUTOBAUD_EN
    task automatic line(input logic v, input int n);
        rxd_mon = v;
        repeat (n) tick();
    endtask

    task automatic frame(input logic [7:0] c);
        line(1'b0, 10);
        for (int i = 0; i < 8; i++) line(c[i], 10);
        line(1'b1, 10);
    endtask

    // Idle line, a 2-cycle glitch, then two 0x55 frames at 10 clocks per bit.
    task automatic calibrate();
        line(1'b1, 80);
        chk("cal_unlocked", locked, 0);
        chk("cal_rx_rst_n", rx_rst_n, 0);
        line(1'b0, 2);
        line(1'b1, 5);
        frame(8'h55);
        frame(8'h55);
        chk("ab_baud", ctrl_baud_clks, 10);
        chk("ab_locked", locked, 1);
        chk("ab_rx_rst_n", rx_rst_n, 1);
    endtask
`endif

    initial begin
`ifdef UART_RX_CTRL_AUTOBAUD_EN
        err_en = 1'b0;
`else
        err_en = 1'b1;
`endif
        rst = 1'b1;
        cfg_baud_clks = 32'd20;
        cfg_bits = 32'd8;
        cfg_stops = 32'd2;
        recal = 1'b0;
        rxd_mon = 1'b1;
        rx_rdy = 1'b0;
        rx_err = 1'b0;
        rx_data = '0;
        ch.out_ready = 1'b0;
        repeat (3) tick();

        chk("rst_rx_rst_n", rx_rst_n, 0);
        chk("rst_locked", locked, 0);
        chk("rst_baud", ctrl_baud_clks, 16);
        chk("rst_bits", ctrl_bits, 8);
        chk("rst_stops", ctrl_stops, 1);
        chk("rst_valid", ch.out_valid, 0);
        chk("rst_data", ch.out_data, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_ovf", ovf_cnt, 0);

        rst = 1'b0;
`ifdef UART_RX_CTRL_AUTOBAUD_EN
        tick();
        chk("hold_unlocked", locked, 0);
        calibrate();
`else
        tick();
        chk("run_locked", locked, 1);
        chk("run_rx_rst_n", rx_rst_n, 1);
        chk("run_baud", ctrl_baud_clks, 20);
        chk("run_stops", ctrl_stops, 2);
        chk("run_bits", ctrl_bits, 8);
        recal = 1'b1;
        tick();
        recal = 1'b0;
        chk("recal_ignored", locked, 1);
        tick();
        chk("recal_ignored2", rx_rst_n, 1);
`endif
        m_run = 1'b1;
        m_bits = 8;

        // Single character, then drain it.
        rx_rdy = 1'b1;
        rx_data = 32'h41;
        cycle();
        rx_rdy = 1'b0;
        chk("chr_41", ch.out_data, 8'h41);
        ch.out_ready = 1'b1;
        cycle();
        ch.out_ready = 1'b0;

        // Nine characters with the consumer stalled: one overflow, first eight kept.
        for (int i = 0; i < 9; i++) begin
            rx_rdy = 1'b1;
            rx_data = {$urandom_range(0, 255) << 8} | 32'(i + 1);
            cycle();
        end
        rx_rdy = 1'b0;
        chk("ovf_9", ovf_cnt, 1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", ch.out_data, i + 1);
            ch.out_ready = 1'b1;
            cycle();
        end
        ch.out_ready = 1'b0;
        chk("drain_empty", ch.out_valid, 0);

        // Fill again, then push and pop together while full.
        for (int i = 0; i < 8; i++) begin
            rx_rdy = 1'b1;
            rx_data = 32'h10 + 32'(i);
            cycle();
        end
        ch.out_ready = 1'b1;
        rx_data = 32'h77;
        cycle();
        rx_rdy = 1'b0;
        chk("full_pushpop_ovf", ovf_cnt, 1);
        chk("full_pushpop_head", ch.out_data, 8'h11);
        repeat (9) cycle();

        // Randomized traffic and back-pressure.
        for (int i = 0; i < 300; i++) begin
            rx_rdy = ($urandom_range(0, 2) == 0);
            rx_err = err_en && ($urandom_range(0, 7) == 0);
            rx_data = $urandom;
            ch.out_ready = $urandom_range(0, 1);
            cycle();
        end
        rx_rdy = 1'b0;
        rx_err = 1'b0;
        ch.out_ready = 1'b1;
        repeat (FIFO_DEPTH + 1) cycle();
        ch.out_ready = 1'b0;

        // One good character, then three framing errors in a row.
        rx_rdy = 1'b1;
        rx_data = 32'h5A;
        cycle();
        rx_err = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        rx_rdy = 1'b0;
        rx_err = 1'b0;
`ifdef UART_RX_CTRL_AUTOBAUD_EN
        m_run = 1'b0;
        chk("err3_cnt", err_cnt, 3);
        chk("err3_locked", locked, 0);
        chk("err3_rx_rst_n", rx_rst_n, 0);
`else
        chk("err3_still_locked", locked, 1);
`endif
        chk("err3_fifo_kept", ch.out_data, 8'h5A);

        // Reset mid-operation with a non-empty FIFO, then 7-bit characters.
        rst = 1'b1;
        cfg_bits = 32'd7;
        tick();
        model_reset();
        chk("midrst_valid", ch.out_valid, 0);
        chk("midrst_data", ch.out_data, 0);
        chk("midrst_err", err_cnt, 0);
        chk("midrst_locked", locked, 0);
        rst = 1'b0;
`ifdef UART_RX_CTRL_AUTOBAUD_EN
        tick();
        calibrate();
`else
        tick();
        chk("relock", locked, 1);
`endif
        chk("bits7_latched", ctrl_bits, 7);
        m_run = 1'b1;
        m_bits = 7;
        rx_rdy = 1'b1;
        rx_data = 32'hC1;
        cycle();
        rx_rdy = 1'b0;
        chk("bits7_data", ch.out_data, 8'h41);
        for (int i = 0; i < 40; i++) begin
            rx_rdy = $urandom_range(0, 1);
            rx_data = $urandom;
            ch.out_ready = $urandom_range(0, 1);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
